// File: rtl/pipe_cache_tag_lookup_pkg.sv
// rtl/pipe_cache_tag_lookup_pkg.sv - shared widths, address slicing and S1 entry type
package pipe_cache_tag_lookup_pkg;

    localparam int ADDR_W   = 32;
    localparam int OFFSET_W = 5;
    localparam int INDEX_W  = 4;
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int NUM_SETS = 1 << INDEX_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              valid;
    } s1_entry_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_W +: INDEX_W];
    endfunction

endpackage

// File: rtl/pipe_cache_tag_lookup_valid_array.sv
// rtl/pipe_cache_tag_lookup_valid_array.sv - per-set valid flops with set, flush and read port
module pipe_cache_valid_array
    import pipe_cache_tag_lookup_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               set_en,
    input  logic [INDEX_W-1:0] set_idx,
    input  logic               flush,
    input  logic [INDEX_W-1:0] rd_idx,
    output logic               rd_valid
);

    logic [NUM_SETS-1:0] valid_q;
    logic [NUM_SETS-1:0] valid_d;

    // Flush clears first so a same-cycle fill still leaves its own bit set.
    always_comb begin
        valid_d = flush ? '0 : valid_q;
        if (set_en) begin
            valid_d[set_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign rd_valid = valid_q[rd_idx];

endmodule

// File: rtl/pipe_cache_tag_lookup.sv
// rtl/pipe_cache_tag_lookup.sv - two-stage direct-mapped tag lookup with fill port and write bypass
module pipe_cache_tag_lookup
    import pipe_cache_tag_lookup_pkg::*;
#(
    parameter int ADDR_WIDTH   = ADDR_W,
    parameter int OFFSET_WIDTH = OFFSET_W,
    parameter int INDEX_WIDTH  = INDEX_W,
    parameter int TAG_WIDTH    = TAG_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic                   resp_hit,
    output logic [ADDR_WIDTH-1:0]  resp_addr,
    output logic                   resp_victim_valid,
    output logic [TAG_WIDTH-1:0]   resp_victim_tag,
    input  logic                   fill_valid,
    input  logic [ADDR_WIDTH-1:0]  fill_addr,
    input  logic                   flush,
    output logic                   tag_csb0,
    output logic [INDEX_WIDTH-1:0] tag_addr0,
    output logic [TAG_WIDTH-1:0]   tag_din0,
    output logic                   tag_csb1,
    output logic [INDEX_WIDTH-1:0] tag_addr1,
    input  logic [TAG_WIDTH-1:0]   tag_dout1
);

    s1_entry_t          s1_q;
    logic               accept;
    logic               byp_valid_q;
    logic [INDEX_W-1:0] byp_idx_q;
    logic [TAG_W-1:0]   byp_tag_q;
    logic [INDEX_W-1:0] s1_idx;
    logic [TAG_W-1:0]   stored_tag;
    logic               set_valid;

    assign req_ready = !s1_q.valid || resp_ready;
    assign accept    = req_valid && req_ready && !rst;

    // Holding csb1 high while stalled keeps the SRAM read address, so dout1 tracks S1.
    assign tag_csb1  = !accept;
    assign tag_addr1 = addr_index(req_addr);

    assign tag_csb0  = !(fill_valid && !rst);
    assign tag_addr0 = addr_index(fill_addr);
    assign tag_din0  = addr_tag(fill_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q.valid <= 1'b0;
        end else if (accept) begin
            s1_q.addr  <= req_addr;
            s1_q.valid <= 1'b1;
        end else if (resp_ready) begin
            s1_q.valid <= 1'b0;
        end
    end

    // The SRAM commits a write one edge after capturing it; the bypass covers that gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            byp_valid_q <= 1'b0;
        end else begin
            byp_valid_q <= fill_valid;
            byp_idx_q   <= addr_index(fill_addr);
            byp_tag_q   <= addr_tag(fill_addr);
        end
    end

    pipe_cache_valid_array u_valid (
        .clk      (clk),
        .rst      (rst),
        .set_en   (fill_valid),
        .set_idx  (addr_index(fill_addr)),
        .flush    (flush),
        .rd_idx   (s1_idx),
        .rd_valid (set_valid)
    );

    assign s1_idx     = addr_index(s1_q.addr);
    assign stored_tag = (byp_valid_q && byp_idx_q == s1_idx) ? byp_tag_q : tag_dout1;

    assign resp_valid        = s1_q.valid;
    assign resp_addr         = s1_q.addr;
    assign resp_victim_valid = set_valid;
    assign resp_victim_tag   = stored_tag;
    assign resp_hit          = set_valid && (stored_tag == addr_tag(s1_q.addr));

endmodule

// File: tb/tb_pipe_cache_tag_lookup.sv
// tb/tb_pipe_cache_tag_lookup.sv - directed bench with behavioural cache model and tag SRAM model
module tb_pipe_cache_tag_lookup;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_hit;
    logic [31:0] resp_addr;
    logic        resp_victim_valid;
    logic [22:0] resp_victim_tag;
    logic        fill_valid;
    logic [31:0] fill_addr;
    logic        flush;
    logic        tag_csb0;
    logic [3:0]  tag_addr0;
    logic [22:0] tag_din0;
    logic        tag_csb1;
    logic [3:0]  tag_addr1;
    logic [22:0] tag_dout1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_cache_tag_lookup dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_addr          (req_addr),
        .resp_valid        (resp_valid),
        .resp_ready        (resp_ready),
        .resp_hit          (resp_hit),
        .resp_addr         (resp_addr),
        .resp_victim_valid (resp_victim_valid),
        .resp_victim_tag   (resp_victim_tag),
        .fill_valid        (fill_valid),
        .fill_addr         (fill_addr),
        .flush             (flush),
        .tag_csb0          (tag_csb0),
        .tag_addr0         (tag_addr0),
        .tag_din0          (tag_din0),
        .tag_csb1          (tag_csb1),
        .tag_addr1         (tag_addr1),
        .tag_dout1         (tag_dout1)
    );

    // Tag SRAM: write commits one edge after capture, read address registered, read data combinational.
    logic [22:0] mem [16];
    logic        wr_pend = 1'b0;
    logic [3:0]  wr_a;
    logic [22:0] wr_d;
    logic [3:0]  rd_a = 4'd0;
    initial for (int i = 0; i < 16; i++) mem[i] = 23'd0;
    always @(posedge clk) begin
        if (wr_pend) mem[wr_a] <= wr_d;
        wr_pend <= !tag_csb0;
        wr_a    <= tag_addr0;
        wr_d    <= tag_din0;
        if (!tag_csb1) rd_a <= tag_addr1;
    end
    assign tag_dout1 = mem[rd_a];

    // Cache model: a set holds whatever the latest fill wrote, effective immediately at the edge.
    bit          m_s1v = 0;
    logic [31:0] m_s1a = 32'd0;
    bit          m_val [16];
    logic [22:0] m_tag [16];
    initial for (int i = 0; i < 16; i++) begin m_val[i] = 0; m_tag[i] = 23'd0; end

    function automatic int idx_of(input logic [31:0] a);
        return int'((a / 32) % 16);
    endfunction
    function automatic logic [22:0] tag_of(input logic [31:0] a);
        return 23'(a / 512);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_s1v = 0;
            for (int i = 0; i < 16; i++) m_val[i] = 0;
        end else begin
            if (req_valid && (!m_s1v || resp_ready)) begin
                m_s1v = 1;
                m_s1a = req_addr;
            end else if (resp_ready) begin
                m_s1v = 0;
            end
            if (flush) for (int i = 0; i < 16; i++) m_val[i] = 0;
            if (fill_valid) begin
                m_val[idx_of(fill_addr)] = 1;
                m_tag[idx_of(fill_addr)] = tag_of(fill_addr);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("req_ready", 32'(req_ready), 32'(!m_s1v || resp_ready));
            chk("resp_valid", 32'(resp_valid), 32'(m_s1v));
            chk("tag_csb1", 32'(tag_csb1), 32'(!(req_valid && (!m_s1v || resp_ready))));
            chk("tag_csb0", 32'(tag_csb0), 32'(!fill_valid));
            if (!tag_csb1) chk("tag_addr1", 32'(tag_addr1), 32'(idx_of(req_addr)));
            if (fill_valid) begin
                chk("tag_addr0", 32'(tag_addr0), 32'(idx_of(fill_addr)));
                chk("tag_din0", 32'(tag_din0), 32'(tag_of(fill_addr)));
            end
            if (m_s1v) begin
                chk("resp_addr", resp_addr, m_s1a);
                chk("resp_victim_valid", 32'(resp_victim_valid), 32'(m_val[idx_of(m_s1a)]));
                chk("resp_victim_tag", 32'(resp_victim_tag), 32'(m_tag[idx_of(m_s1a)]));
                chk("resp_hit", 32'(resp_hit),
                    32'(m_val[idx_of(m_s1a)] && m_tag[idx_of(m_s1a)] == tag_of(m_s1a)));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [31:0] a);
        req_valid = 1'b1;
        req_addr  = a;
        cyc();
        req_valid = 1'b0;
    endtask

    task automatic fill(input logic [31:0] a, input bit with_flush);
        fill_valid = 1'b1;
        fill_addr  = a;
        flush      = with_flush;
        cyc();
        fill_valid = 1'b0;
        flush      = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = 32'd0; resp_ready = 1'b1;
        fill_valid = 1'b0; fill_addr = 32'd0; flush = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("reset resp_valid", 32'(resp_valid), 32'd0);
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset tag_csb0", 32'(tag_csb0), 32'd1);
        chk("reset tag_csb1", 32'(tag_csb1), 32'd1);
        cyc();

        lookup(32'h0000_0040);
        @(negedge clk);
        chk("cold resp_valid", 32'(resp_valid), 32'd1);
        chk("cold resp_hit", 32'(resp_hit), 32'd0);
        chk("cold victim_valid", 32'(resp_victim_valid), 32'd0);
        cyc();

        fill(32'h1234_5660, 0);
        cyc();
        lookup(32'h1234_5678);
        @(negedge clk);
        chk("sram hit", 32'(resp_hit), 32'd1);
        chk("sram victim_tag", 32'(resp_victim_tag), 32'h0009_1A2B);
        cyc();

        // Fill and lookup same cycle, then the same lookup once more.
        req_valid = 1'b1; req_addr = 32'hABCD_0020;
        fill(32'hABCD_0020, 0);
        @(negedge clk);
        chk("bypass hit", 32'(resp_hit), 32'd1);
        chk("bypass victim_tag", 32'(resp_victim_tag), 32'h0055_E680);
        cyc();
        req_valid = 1'b0;
        @(negedge clk);
        chk("post-bypass hit", 32'(resp_hit), 32'd1);
        cyc();

        // Stall S1 for three cycles with the next request waiting.
        resp_ready = 1'b0;
        lookup(32'h1234_5678);
        req_valid = 1'b1; req_addr = 32'h0000_0040;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall req_ready", 32'(req_ready), 32'd0);
            chk("stall tag_csb1", 32'(tag_csb1), 32'd1);
            chk("stall resp_addr", resp_addr, 32'h1234_5678);
            chk("stall resp_hit", 32'(resp_hit), 32'd1);
            cyc();
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk("release req_ready", 32'(req_ready), 32'd1);
        chk("release tag_csb1", 32'(tag_csb1), 32'd0);
        cyc();
        req_valid = 1'b0;
        @(negedge clk);
        chk("release next addr", resp_addr, 32'h0000_0040);
        cyc();

        // A fill landing while S1 is stalled turns the miss into a hit.
        resp_ready = 1'b0;
        lookup(32'h2000_0080);
        @(negedge clk);
        chk("stall miss", 32'(resp_hit), 32'd0);
        fill(32'h2000_0080, 0);
        @(negedge clk);
        chk("stall fill hit", 32'(resp_hit), 32'd1);
        chk("stall fill tag", 32'(resp_victim_tag), 32'h0010_0000);
        cyc(); cyc();
        resp_ready = 1'b1;
        cyc();

        // Flush together with a fill keeps only the new fill valid.
        fill(32'h0000_00A0, 0);
        fill(32'h00FF_00E0, 1);
        cyc();
        lookup(32'h0000_00A0);
        @(negedge clk);
        chk("flushed idx5 miss", 32'(resp_hit), 32'd0);
        lookup(32'h00FF_00E0);
        @(negedge clk);
        chk("flush-fill idx7 hit", 32'(resp_hit), 32'd1);
        lookup(32'h1234_5678);
        @(negedge clk);
        chk("flushed idx3 miss", 32'(resp_hit), 32'd0);
        cyc();

        // Back-to-back fills to one set, newest tag wins.
        fill(32'h0100_0040, 0);
        req_valid = 1'b1; req_addr = 32'h0200_0040;
        fill(32'h0200_0040, 0);
        req_valid = 1'b0;
        @(negedge clk);
        chk("b2b newest hit", 32'(resp_hit), 32'd1);
        cyc();

        // Reset with a response pending drops it and clears the valid bits.
        fill(32'h5550_0040, 0);
        cyc();
        resp_ready = 1'b0;
        lookup(32'h5550_0040);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("rst drops resp", 32'(resp_valid), 32'd0);
        cyc();
        lookup(32'h5550_0040);
        @(negedge clk);
        chk("rst lookup miss", 32'(resp_hit), 32'd0);
        cyc(); cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
